// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_pkg
// Purpose  : Shared types and constants for the LED pattern sequencer:
//            display-mode encoding, per-mode seed patterns and a seed lookup.
// Revision : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    localparam logic [15:0] SEED_SHIFT  = 16'h0001;
    localparam logic [15:0] SEED_BOUNCE = 16'h0001;
    localparam logic [15:0] SEED_BLINK  = 16'hFFFF;

    // Pattern loaded into the LED register when a mode is applied.
    function automatic logic [15:0] seed_of(input mode_t m);
        logic [15:0] s;
        case (m)
            MODE_SHIFT:  s = SEED_SHIFT;
            MODE_BOUNCE: s = SEED_BOUNCE;
            MODE_BLINK:  s = SEED_BLINK;
            default:     s = 16'h0000;
        endcase
        return s;
    endfunction

endpackage : led_seq_pkg
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_tick_gen
// Purpose  : Step prescaler. Counts 0..TICK_CYCLES-1 and raises a registered
//            one-cycle tick while the count sits at TICK_CYCLES-1.
// Ports    : clk   - system clock
//            rst_n - asynchronous active-low reset
//            hold  - freeze the count, suppress tick
//            clear - restart the count from 0 (wins over hold)
//            tick  - one-cycle step pulse
// Revision : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter  int TICK_CYCLES = 100_000_000,
    localparam int CNT_W       = $clog2(TICK_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q,  tick_d;

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (hold) begin
            count_d = count_q;
        end else if (count_q == LAST) begin
            // A hold that started while the count was at LAST swallowed the
            // tick; issue it now instead of wrapping, so no step is lost.
            if (tick_q) begin
                count_d = '0;
            end else begin
                tick_d  = 1'b1;
            end
        end else begin
            count_d = count_q + CNT_W'(1);
            tick_d  = (count_d == LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule : led_tick_gen
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_sequencer
// Purpose  : Drives a 16-LED bank through OFF / SHIFT / BOUNCE / BLINK
//            patterns. Mode requests arrive over valid/ready and are applied
//            on step boundaries (immediately when OFF or paused).
// Ports    : clk, rst_n (async active-low)
//            mode_req_valid / mode_req / mode_req_ready - mode request handshake
//            pause  - freeze prescaler and pattern
//            mode   - currently applied mode
//            tick   - one-cycle pulse per pattern step
//            LED    - LED drive, bit 0 rightmost
//            brightness - 4-bit PWM duty (only with LED_PWM_EN)
// Config   : `define LED_PWM_EN adds brightness input and PWM gating of LED.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode_req_valid,
    input  logic [1:0]  mode_req,
    output logic        mode_req_ready,
    input  logic        pause,
`ifdef LED_PWM_EN
    input  logic [3:0]  brightness,
`endif
    output logic [1:0]  mode,
    output logic        tick,
    output logic [15:0] LED
);

    mode_t       mode_q,     mode_d;
    mode_t       pend_mode_q, pend_mode_d;
    logic        pending_q,  pending_d;
    logic [15:0] led_q,      led_d;
    logic        dir_up_q,   dir_up_d;

    logic        w_tick;
    logic        w_accept;
    logic        w_apply;
    logic        w_step;

    led_tick_gen #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (pause),
        .clear (w_apply),
        .tick  (w_tick)
    );

    // A request accepted in a tick cycle is only pending from the next
    // cycle on, so it naturally waits for the following tick.
    assign w_accept = mode_req_valid && !pending_q;
    assign w_apply  = pending_q && (w_tick || pause || (mode_q == MODE_OFF));
    assign w_step   = w_tick && !pause;

    always_comb begin
        mode_d      = mode_q;
        pend_mode_d = pend_mode_q;
        pending_d   = pending_q;
        led_d       = led_q;
        dir_up_d    = dir_up_q;

        if (w_accept) begin
            pending_d   = 1'b1;
            pend_mode_d = mode_t'(mode_req);
        end

        if (w_apply) begin
            mode_d    = pend_mode_q;
            led_d     = seed_of(pend_mode_q);
            dir_up_d  = 1'b1;
            pending_d = 1'b0;
        end else if (w_step) begin
            case (mode_q)
                MODE_SHIFT:  led_d = {led_q[14:0], led_q[15]};
                MODE_BOUNCE: begin
                    led_d = dir_up_q ? (led_q << 1) : (led_q >> 1);
                    // Flip at the ends so the next step heads back inward.
                    if (led_d == 16'h8000) begin
                        dir_up_d = 1'b0;
                    end else if (led_d == 16'h0001) begin
                        dir_up_d = 1'b1;
                    end
                end
                MODE_BLINK:  led_d = ~led_q;
                default:     led_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_OFF;
            pend_mode_q <= MODE_OFF;
            pending_q   <= 1'b0;
            led_q       <= 16'h0000;
            dir_up_q    <= 1'b1;
        end else begin
            mode_q      <= mode_d;
            pend_mode_q <= pend_mode_d;
            pending_q   <= pending_d;
            led_q       <= led_d;
            dir_up_q    <= dir_up_d;
        end
    end

    assign mode_req_ready = !pending_q;
    assign mode           = mode_q;
    assign tick           = w_tick;

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt_q, pwm_cnt_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= 4'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign LED = led_q & {16{pwm_cnt_q < brightness}};
`else
    assign LED = led_q;
`endif

endmodule : led_pattern_sequencer
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_sequencer
// Purpose  : Self-checking bench for led_pattern_sequencer (TICK_CYCLES=4).
//            Expected LED values per step are queued when a mode is started
//            and compared as the DUT produces each step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_sequencer;

    localparam int TICK_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode_req_valid = 1'b0;
    logic [1:0]  mode_req = 2'd0;
    logic        mode_req_ready;
    logic        pause = 1'b0;
    logic [1:0]  mode;
    logic        tick;
    logic [15:0] LED;
`ifdef LED_PWM_EN
    logic [3:0]  brightness = 4'd15;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    led_pattern_sequencer #(
        .TICK_CYCLES (TICK_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mode_req_valid (mode_req_valid),
        .mode_req       (mode_req),
        .mode_req_ready (mode_req_ready),
        .pause          (pause),
`ifdef LED_PWM_EN
        .brightness     (brightness),
`endif
        .mode           (mode),
        .tick           (tick),
        .LED            (LED)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mode_req_valid = 1'b0;
        pause = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Present a request for one cycle; returns at the following negedge.
    task automatic request(input logic [1:0] m);
        mode_req = m;
        mode_req_valid = 1'b1;
        @(negedge clk);
        mode_req_valid = 1'b0;
    endtask

    // Wait (bounded) for the next tick, then compare the stepped LED value.
    task automatic step_tick(input string tag, input bit chk_onehot);
        int n = 0;
        logic [15:0] e;
        while (tick !== 1'b1 && n < 4 * TICK_CYCLES) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) check({tag, "_tick_timeout"}, 32'(tick), 32'd1);
        @(negedge clk);
        e = exp_q.pop_front();
        check(tag, 32'(LED), 32'(e));
        if (chk_onehot) check({tag, "_onehot"}, 32'($onehot(LED)), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_led",   32'(LED), 32'h0);
        check("rst_mode",  32'(mode), 32'd0);
        check("rst_ready", 32'(mode_req_ready), 32'd1);
        check("rst_tick",  32'(tick), 32'd0);
        do_reset();

        // ---------------- 1: SHIFT from OFF, 16-step wrap ----------------
        request(2'd1);
        check("t1_ready_low", 32'(mode_req_ready), 32'd0);
        @(negedge clk);
        check("t1_mode", 32'(mode), 32'd1);
        check("t1_seed", 32'(LED), 32'h0001);
        check("t1_ready_back", 32'(mode_req_ready), 32'd1);
        for (int k = 1; k <= 16; k++) exp_q.push_back(16'h0001 << (k % 16));
        for (int k = 1; k <= 16; k++) step_tick("t1_shift", 1'b1);

        // ---------------- 2: BOUNCE from OFF, 31 steps ----------------
        do_reset();
        request(2'd2);
        @(negedge clk);
        check("t2_mode", 32'(mode), 32'd2);
        check("t2_seed", 32'(LED), 32'h0001);
        for (int k = 1; k <= 31; k++) begin
            int pos;
            pos = (k <= 15) ? k : ((k <= 30) ? 30 - k : k - 30);
            exp_q.push_back(16'h0001 << pos);
        end
        for (int k = 1; k <= 31; k++) step_tick("t2_bounce", 1'b1);

        // ---------------- 3: BLINK requested two cycles before tick --------
        do_reset();
        request(2'd1);
        @(negedge clk);
        exp_q.push_back(16'h0002);
        exp_q.push_back(16'h0004);
        step_tick("t3_shift", 1'b1);
        step_tick("t3_shift", 1'b1);
        @(negedge clk);                       // count = 1
        mode_req = 2'd3;
        mode_req_valid = 1'b1;
        @(negedge clk);                       // count = 2
        mode_req_valid = 1'b0;
        check("t3_ready_wait1", 32'(mode_req_ready), 32'd0);
        @(negedge clk);                       // count = 3, tick high
        check("t3_ready_wait2", 32'(mode_req_ready), 32'd0);
        check("t3_tick", 32'(tick), 32'd1);
        check("t3_mode_old", 32'(mode), 32'd1);
        @(negedge clk);
        check("t3_mode_new", 32'(mode), 32'd3);
        check("t3_blink_seed", 32'(LED), 32'hFFFF);
        check("t3_ready_back", 32'(mode_req_ready), 32'd1);
        exp_q.push_back(16'h0000);
        step_tick("t3_blink", 1'b0);

        // ---------------- 4: request in the tick cycle ----------------
        begin
            int n = 0;
            while (tick !== 1'b1 && n < 4 * TICK_CYCLES) begin
                @(negedge clk);
                n++;
            end
            check("t4_tick_seen", 32'(tick), 32'd1);
        end
        mode_req = 2'd1;
        mode_req_valid = 1'b1;
        @(negedge clk);
        mode_req_valid = 1'b0;
        check("t4_blink_step", 32'(LED), 32'hFFFF);
        check("t4_mode_kept", 32'(mode), 32'd3);
        check("t4_ready_low", 32'(mode_req_ready), 32'd0);
        repeat (TICK_CYCLES - 1) @(negedge clk);
        check("t4_tick_again", 32'(tick), 32'd1);
        check("t4_mode_before", 32'(mode), 32'd3);
        @(negedge clk);
        check("t4_mode_applied", 32'(mode), 32'd1);
        check("t4_led_applied", 32'(LED), 32'h0001);

        // ---------------- 5: pause in BLINK, request while paused --------
        do_reset();
        request(2'd3);
        @(negedge clk);
        check("t5_seed", 32'(LED), 32'hFFFF);
        exp_q.push_back(16'h0000);
        step_tick("t5_blink", 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_pause_led", 32'(LED), 32'h0000);
            check("t5_pause_tick", 32'(tick), 32'd0);
        end
        pause = 1'b0;
        @(negedge clk);
        check("t5_resume1", 32'(tick), 32'd0);
        @(negedge clk);
        check("t5_resume2", 32'(tick), 32'd0);
        @(negedge clk);
        check("t5_resume3", 32'(tick), 32'd1);
        pause = 1'b1;
        mode_req = 2'd2;
        mode_req_valid = 1'b1;
        @(negedge clk);
        mode_req_valid = 1'b0;
        check("t5_held_at_tick", 32'(LED), 32'h0000);
        check("t5_ready_low", 32'(mode_req_ready), 32'd0);
        @(negedge clk);
        check("t5_mode", 32'(mode), 32'd2);
        check("t5_bounce_seed", 32'(LED), 32'h0001);
        pause = 1'b0;

        // ---------------- 6: async reset mid-BOUNCE ----------------
        for (int k = 1; k <= 9; k++) exp_q.push_back(16'h0001 << k);
        for (int k = 1; k <= 9; k++) step_tick("t6_bounce", 1'b1);
        check("t6_led_pre", 32'(LED), 32'h0200);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_led", 32'(LED), 32'h0000);
        check("t6_async_mode", 32'(mode), 32'd0);
        check("t6_async_ready", 32'(mode_req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef LED_PWM_EN
        // ---------------- PWM duty: brightness 4 of 16 ----------------
        brightness = 4'd4;
        request(2'd1);
        @(negedge clk);
        begin
            int lit = 0;
            for (int i = 0; i < 16; i++) begin
                if (LED != 16'h0000) lit++;
                @(negedge clk);
            end
            check("pwm_duty", 32'(lit), 32'd4);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_led_pattern_sequencer
`default_nettype wire
